step_pacer: RTL and testbench

Parametrised pipeline pacing and observation unit for the kakacpu top level. It generates the single-cycle `valid_input` pulses that advance the fetch stage, in one of four modes: free-run at an exact period, single-step per button press, pause, or burst of N steps per press. It also latches a selectable byte of the observed stage output onto the LEDs. It replaces the fixed 50 M-cycle tick counter and the LED latch in the top level.

---
 rtl/kaka_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/step_pacer.sv | 133 +++++++++++++
 tb/tb_step_pacer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/kaka_pkg.sv
// Shared types for the kakacpu top-level pacing logic: run modes, pacer FSM states
// and the mode-to-entry-state mapping.
package kaka_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    ModeRun   = 2'b00,
    ModeStep  = 2'b01,
    ModePause = 2'b10,
    ModeBurst = 2'b11
  } pace_mode_t;

  typedef enum logic [2:0] {
    S_RUN,
    S_STEP,
    S_PAUSE,
    S_BURST_IDLE,
    S_BURST_ACT
  } pace_state_t;

  function automatic pace_state_t entry_state(input pace_mode_t m);
    pace_state_t s;
    unique case (m)
      ModeRun:   s = S_RUN;
      ModeStep:  s = S_STEP;
      ModePause: s = S_PAUSE;
      default:   s = S_BURST_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces an active-low push button; emits a one-cycle press pulse
// one cycle after the debounced level falls.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic            press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    cnt_d   = '0;
    level_d = level_q;
    // Count consecutive cycles the synchronised input disagrees with the accepted level.
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_dly_q & ~level_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/step_pacer.sv
// Paces fetch-stage step pulses (free-run, single-step, pause, burst) and latches a
// selectable slice of the observed stage output onto the LEDs.
module step_pacer
  import kaka_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int unsigned STEP_HZ         = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned LED_W           = 8,
  parameter int unsigned BURST_W         = 8,
  localparam int unsigned SEL_W = (DATA_W / LED_W > 1) ? $clog2(DATA_W / LED_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               step_btn_n,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stall_input,
  output logic               valid_output,
  input  logic               obs_valid,
  input  logic [DATA_W-1:0]  obs_data,
  input  logic [SEL_W-1:0]   byte_sel,
  output logic [LED_W-1:0]   led,
  output logic [31:0]        step_count
);

  localparam int unsigned PERIOD  = CLK_HZ / STEP_HZ;
  localparam int unsigned PerW    = $clog2(PERIOD);
  localparam int unsigned NSlices = DATA_W / LED_W;
  localparam logic [PerW-1:0]    PerLast  = PerW'(PERIOD - 1);
  localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

  pace_mode_t         mode_in, mode_q;
  pace_state_t        state_q, state_d;
  logic               pending_q, pending_d;
  logic [PerW-1:0]    per_q, per_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [31:0]        step_cnt_q, step_cnt_d;
  logic               press, unused_level;
  logic               mode_chg, issue, due;
  logic [SEL_W-1:0]   sel;
  int unsigned        slice_lo;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst  (rst),
    .btn_n(step_btn_n),
    .level(unused_level),
    .press(press)
  );

  assign mode_in  = pace_mode_t'(mode);
  assign mode_chg = (mode_in != mode_q);
  // A mode change cancels the pending step in the same cycle, so it never escapes.
  assign issue        = pending_q & ~stall_input & ~mode_chg;
  assign valid_output = issue;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    rem_d   = rem_q;
    due     = 1'b0;
    if (mode_chg) begin
      state_d = entry_state(mode_in);
      per_d   = '0;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          due   = (per_q == PerLast);
          per_d = (per_q == PerLast) ? '0 : per_q + 1'b1;
        end
        S_STEP:  due = press;
        S_PAUSE: due = 1'b0;
        S_BURST_IDLE: begin
          if (press && (burst_len != '0)) begin
            due     = 1'b1;
            rem_d   = burst_len;
            state_d = S_BURST_ACT;
          end
        end
        S_BURST_ACT: begin
          // Re-arm on the issuing cycle unless that issue is the last one of the burst.
          due = ~pending_q | (issue & (rem_q != BurstOne));
          if (issue) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == BurstOne) begin
              state_d = S_BURST_IDLE;
            end
          end
        end
        default: state_d = entry_state(mode_in);
      endcase
    end
    pending_d = ~mode_chg & (due | (pending_q & ~issue));
  end

  always_comb begin
    sel        = (32'(byte_sel) < NSlices) ? byte_sel : '0;
    slice_lo   = 32'(sel) * LED_W;
    led_d      = obs_valid ? obs_data[slice_lo +: LED_W] : led_q;
    step_cnt_d = issue ? step_cnt_q + 32'd1 : step_cnt_q;
  end

  // Reset lands in RUN; a different mode input is picked up as a change on the first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= ModeRun;
      state_q    <= S_RUN;
      pending_q  <= 1'b0;
      per_q      <= '0;
      rem_q      <= '0;
      led_q      <= '0;
      step_cnt_q <= '0;
    end else begin
      mode_q     <= mode_in;
      state_q    <= state_d;
      pending_q  <= pending_d;
      per_q      <= per_d;
      rem_q      <= rem_d;
      led_q      <= led_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign led        = led_q;
  assign step_count = step_cnt_q;

endmodule

// File: tb/tb_step_pacer.sv
// Self-checking bench for step_pacer: expected pulse cycles are queued when stimulus is
// driven and popped as valid_output pulses appear.
module tb_step_pacer;
  import kaka_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        step_btn_n = 1'b1;
  logic [7:0]  burst_len = '0;
  logic        stall_input = 1'b0;
  logic        valid_output;
  logic        obs_valid = 1'b0;
  logic [31:0] obs_data = '0;
  logic [1:0]  byte_sel = '0;
  logic [7:0]  led;
  logic [31:0] step_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  step_pacer #(
    .CLK_HZ         (8),
    .STEP_HZ        (2),
    .DEBOUNCE_CYCLES(4),
    .DATA_W         (32),
    .LED_W          (8),
    .BURST_W        (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .step_btn_n  (step_btn_n),
    .burst_len   (burst_len),
    .stall_input (stall_input),
    .valid_output(valid_output),
    .obs_valid   (obs_valid),
    .obs_data    (obs_data),
    .byte_sel    (byte_sel),
    .led         (led),
    .step_count  (step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every pulse must match the next queued expected cycle.
  always @(negedge clk) begin
    if (rst && valid_output) begin
      if (exp_q.size() == 0) check_eq("unexpected_pulse", valid_output, 1'b0);
      else check_eq("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  // Inputs change only at posedge+1; cyc then names the current cycle.
  task automatic step_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic all_seen(input string tag);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [1:0] m, output int base);
    rst         = 1'b0;
    mode        = m;
    stall_input = 1'b0;
    step_btn_n  = 1'b1;
    step_to(cyc + 2);
    check_eq("rst_valid", valid_output, 1'b0);
    check_eq("rst_led", led, 0);
    check_eq("rst_count", step_count, 0);
    check_eq("rst_pending", dut.pending_q, 1'b0);
    rst  = 1'b1;
    base = cyc;
  endtask

  initial begin
    int b, f, m, c;
    #1;

    // Free-run, PERIOD = 4: pulses 4, 8, 12 cycles after reset release.
    do_reset(2'b00, b);
    exp_q.push_back(b + 4);
    exp_q.push_back(b + 8);
    exp_q.push_back(b + 12);
    step_to(b + 13);
    check_eq("run_count", step_count, 3);
    all_seen("run_missing");
    mode = 2'b10;
    step_to(b + 20);
    check_eq("pause_count", step_count, 3);

    // Stall cycles 3..9: step due at 4 waits until 10, the one due at 8 is dropped.
    do_reset(2'b00, b);
    exp_q.push_back(b + 10);
    exp_q.push_back(b + 12);
    step_to(b + 3);
    stall_input = 1'b1;
    step_to(b + 10);
    stall_input = 1'b0;
    step_to(b + 13);
    check_eq("stall_count", step_count, 2);
    all_seen("stall_missing");
    mode = 2'b10;
    step_to(b + 16);

    // Single-step: a 2-cycle glitch is rejected, a 10-cycle press gives one pulse
    // at 2 sync + 4 debounce + 1 press + 1 issue = 8 cycles after the falling edge.
    mode = 2'b01;
    step_to(cyc + 2);
    f = cyc;
    step_btn_n = 1'b0;
    step_to(f + 2);
    step_btn_n = 1'b1;
    step_to(f + 12);
    f = cyc;
    exp_q.push_back(f + 8);
    step_btn_n = 1'b0;
    step_to(f + 10);
    step_btn_n = 1'b1;
    step_to(f + 25);
    check_eq("step_count", step_count, 3);
    all_seen("step_missing");

    // Burst of 3 with the 2nd step stalled for 2 cycles.
    mode      = 2'b11;
    burst_len = 8'd3;
    step_to(cyc + 2);
    f = cyc;
    exp_q.push_back(f + 8);
    exp_q.push_back(f + 11);
    exp_q.push_back(f + 12);
    step_btn_n = 1'b0;
    step_to(f + 9);
    stall_input = 1'b1;
    step_to(f + 10);
    step_btn_n = 1'b1;
    step_to(f + 11);
    stall_input = 1'b0;
    step_to(f + 25);
    check_eq("burst_count", step_count, 6);
    check_eq("burst_idle", dut.state_q, S_BURST_IDLE);
    all_seen("burst_missing");

    // burst_len == 0 is ignored.
    burst_len = 8'd0;
    f = cyc;
    step_btn_n = 1'b0;
    step_to(f + 10);
    step_btn_n = 1'b1;
    step_to(f + 25);
    check_eq("burst0_count", step_count, 6);
    check_eq("burst0_idle", dut.state_q, S_BURST_IDLE);

    // Burst of 5 cut short by PAUSE after the first pulse.
    burst_len = 8'd5;
    f = cyc;
    exp_q.push_back(f + 8);
    step_btn_n = 1'b0;
    step_to(f + 9);
    mode = 2'b10;
    step_to(f + 10);
    step_btn_n = 1'b1;
    check_eq("pause_pending", dut.pending_q, 1'b0);
    step_to(f + 20);
    check_eq("cut_count", step_count, 7);
    all_seen("cut_missing");

    // Back to RUN: FSM enters RUN at m+1, first pulse 4 cycles after that.
    m = cyc;
    mode = 2'b00;
    exp_q.push_back(m + 5);
    step_to(m + 6);
    mode = 2'b10;
    check_eq("rerun_count", step_count, 8);
    all_seen("rerun_missing");

    // LED latch, hold and slice selection.
    c = cyc;
    obs_data  = 32'hA1B2C3D4;
    byte_sel  = 2'd2;
    obs_valid = 1'b1;
    step_to(c + 1);
    obs_valid = 1'b0;
    byte_sel  = 2'd0;
    obs_data  = 32'h0;
    check_eq("led_sel2", led, 8'hB2);
    step_to(c + 3);
    check_eq("led_hold", led, 8'hB2);
    obs_data  = 32'hA1B2C3D4;
    byte_sel  = 2'd3;
    obs_valid = 1'b1;
    step_to(c + 4);
    check_eq("led_sel3", led, 8'hA1);
    byte_sel = 2'd0;
    step_to(c + 5);
    obs_valid = 1'b0;
    check_eq("led_sel0", led, 8'hD4);

    // Reset in the middle of a burst: everything clears and nothing follows.
    mode = 2'b11;
    step_to(cyc + 2);
    f = cyc;
    exp_q.push_back(f + 8);
    exp_q.push_back(f + 9);
    step_btn_n = 1'b0;
    step_to(f + 10);
    step_btn_n = 1'b1;
    rst = 1'b0;
    #1;
    check_eq("midrst_valid", valid_output, 1'b0);
    check_eq("midrst_led", led, 0);
    check_eq("midrst_count", step_count, 0);
    step_to(f + 12);
    rst = 1'b1;
    step_to(f + 30);
    check_eq("post_rst_count", step_count, 0);
    all_seen("midrst_missing");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
